// File: rtl/blink_timer_pkg.sv
// Shared definitions for the blink timer: FSM state encoding and default counter width.
package blink_timer_pkg;

    localparam int PW_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/blink_timer_if.sv
// Control/status bundle between the sequencing logic (master) and one blink timer (slave).
interface blink_timer_if
    import blink_timer_pkg::*;
#(
    parameter int PW = PW_DEF
);

    // No valid/ready pair: load_val is a level that the timer samples only when it
    // reloads or clamps, and enable/hold are levels acted on at the next clock edge.
    logic          enable;
    logic          hold;
    logic [PW-1:0] load_val;
    logic          led;
    logic          expire;
    logic [PW-1:0] count;
    logic          busy;
    state_e        state;

    modport master (
        output enable, hold, load_val,
        input  led, expire, count, busy, state
    );

    modport slave (
        input  enable, hold, load_val,
        output led, expire, count, busy, state
    );

endinterface

// File: rtl/blink_timer_tick_prescaler.sv
// Divides clk into timer ticks: one tick every PRESCALE cycles while run is high.
module tick_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clr,
    output logic tick
);

    localparam int PCW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PCW-1:0] LAST = PCW'(PRESCALE - 1);

    logic [PCW-1:0] pcnt_q;

    assign tick = run && (pcnt_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q <= '0;
        end else if (clr) begin
            pcnt_q <= '0;
        end else if (run) begin
            pcnt_q <= (pcnt_q == LAST) ? '0 : pcnt_q + PCW'(1);
        end
    end

endmodule

// File: rtl/blink_timer.sv
// Loadable down-counting blink timer: toggles led every (load_val+1)*PRESCALE cycles
// and pulses expire one cycle after each toggling tick.
module blink_timer
    import blink_timer_pkg::*;
#(
    parameter int PRESCALE = 1,
    parameter int PW       = PW_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    blink_timer_if.slave      bus
);

    state_e        state_q, state_d;
    logic [PW-1:0] count_q, count_d;
    logic [PW-1:0] count_dec;
    logic          led_q, led_d;
    logic          expire_q, expire_d;
    logic          pre_run, pre_clr, tick;

    // Prescaler advances only in an un-held RUN cycle that is not being shut down.
    assign pre_run = (state_q == ST_RUN) && bus.enable && !bus.hold;
    assign pre_clr = (state_q == ST_IDLE) || !bus.enable;

    tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (pre_run),
        .clr   (pre_clr),
        .tick  (tick)
    );

    assign count_dec = count_q - PW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            led_q    <= 1'b0;
            expire_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            led_q    <= led_d;
            expire_q <= expire_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        led_d    = led_q;
        expire_d = 1'b0;
        if (!bus.enable) begin
            state_d = ST_IDLE;
            count_d = '0;
            led_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_RUN;
                    count_d = bus.load_val;
                    led_d   = 1'b0;
                end
                ST_RUN: begin
                    if (bus.hold) begin
                        state_d = ST_HOLD;
                    end else if (tick) begin
                        if (count_q == '0) begin
                            count_d  = bus.load_val;
                            led_d    = ~led_q;
                            expire_d = 1'b1;
                        end else if (count_dec > bus.load_val) begin
                            count_d = bus.load_val;
                        end else begin
                            count_d = count_dec;
                        end
                    end else if (bus.load_val < count_q) begin
                        // A shorter period takes effect at once instead of after the old one.
                        count_d = bus.load_val;
                    end
                end
                ST_HOLD: begin
                    if (!bus.hold) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    count_d = '0;
                    led_d   = 1'b0;
                end
            endcase
        end
    end

    assign bus.led    = led_q;
    assign bus.expire = expire_q;
    assign bus.count  = count_q;
    assign bus.busy   = (state_q != ST_IDLE);
    assign bus.state  = state_q;

endmodule

// File: tb/tb_blink_timer.sv
// Bench for blink_timer: vector table, corner-case sequences and a random run against a model.
module tb_blink_timer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  blink_timer_if #(.PW(8)) if1 ();
  blink_timer_if #(.PW(8)) if4 ();

  blink_timer #(.PRESCALE(1), .PW(8)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  blink_timer #(.PRESCALE(4), .PW(8)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));

  typedef struct {
    bit         en;
    bit         hd;
    logic [7:0] lv;
    bit         led;
    bit         exp;
    logic [7:0] cnt;
    bit         busy;
  } vec_t;

  typedef struct {
    int mode;      // 0 idle, 1 run, 2 hold
    int cnt;
    bit led;
    bit exp;
    int run_cycles;
    int ps;
  } model_t;

  vec_t   vecs[24];
  model_t m1, m4;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input bit led, input bit exp, input int cnt, input bit busy);
    check({name, ".led"}, 32'(if1.led), 32'(led));
    check({name, ".expire"}, 32'(if1.expire), 32'(exp));
    check({name, ".count"}, 32'(if1.count), cnt);
    check({name, ".busy"}, 32'(if1.busy), 32'(busy));
  endtask

  task automatic drive1(input bit en, input bit hd, input int lv);
    if1.enable = en;
    if1.hold = hd;
    if1.load_val = 8'(lv);
  endtask

  // Reference: tick whenever the number of un-held RUN cycles so far is one short of a multiple of ps.
  function automatic model_t model_next(model_t m, bit en, bit hd, int lv);
    model_t n = m;
    bit tk;
    n.exp = 1'b0;
    if (!en) begin
      n.mode = 0; n.cnt = 0; n.led = 1'b0; n.run_cycles = 0;
      return n;
    end
    case (m.mode)
      0: begin n.mode = 1; n.cnt = lv; n.led = 1'b0; n.run_cycles = 0; end
      1: begin
        if (hd) n.mode = 2;
        else begin
          tk = ((m.run_cycles % m.ps) == m.ps - 1);
          n.run_cycles = m.run_cycles + 1;
          if (tk && m.cnt == 0) begin n.cnt = lv; n.led = !m.led; n.exp = 1'b1; end
          else if (tk) n.cnt = (m.cnt - 1 < lv) ? m.cnt - 1 : lv;
          else if (lv < m.cnt) n.cnt = lv;
        end
      end
      default: if (!hd) n.mode = 1;
    endcase
    return n;
  endfunction

  function automatic model_t model_reset(int ps);
    model_t m;
    m.mode = 0; m.cnt = 0; m.led = 1'b0; m.exp = 1'b0; m.run_cycles = 0; m.ps = ps;
    return m;
  endfunction

  initial begin
    bit found;
    bit led_prev, led_save;
    int exp_cnt, led_chg;
    int exp_at[$];
    int lv1, lv4;

    drive1(0, 0, 0);
    if4.enable = 1'b0; if4.hold = 1'b0; if4.load_val = 8'd0;
    repeat (2) @(negedge clk);
    check1("reset", 0, 0, 0, 0);
    check("reset4.busy", 32'(if4.busy), 0);
    rst_n = 1'b1;

    // PRESCALE=1 vector table: inputs applied before an edge, outputs expected after it
    vecs[0]  = '{1, 0, 3, 0, 0, 3, 1};
    vecs[1]  = '{1, 0, 3, 0, 0, 2, 1};
    vecs[2]  = '{1, 0, 3, 0, 0, 1, 1};
    vecs[3]  = '{1, 0, 3, 0, 0, 0, 1};
    vecs[4]  = '{1, 0, 3, 1, 1, 3, 1};
    vecs[5]  = '{1, 0, 3, 1, 0, 2, 1};
    vecs[6]  = '{1, 0, 3, 1, 0, 1, 1};
    vecs[7]  = '{1, 0, 3, 1, 0, 0, 1};
    vecs[8]  = '{1, 0, 3, 0, 1, 3, 1};
    vecs[9]  = '{1, 0, 1, 0, 0, 1, 1};
    vecs[10] = '{1, 0, 1, 0, 0, 0, 1};
    vecs[11] = '{1, 0, 1, 1, 1, 1, 1};
    vecs[12] = '{1, 0, 1, 1, 0, 0, 1};
    vecs[13] = '{0, 0, 1, 0, 0, 0, 0};
    vecs[14] = '{0, 0, 1, 0, 0, 0, 0};
    vecs[15] = '{1, 0, 5, 0, 0, 5, 1};
    vecs[16] = '{1, 1, 5, 0, 0, 5, 1};
    vecs[17] = '{1, 1, 5, 0, 0, 5, 1};
    vecs[18] = '{1, 0, 5, 0, 0, 5, 1};
    vecs[19] = '{1, 0, 5, 0, 0, 4, 1};
    vecs[20] = '{1, 0, 0, 0, 0, 0, 1};
    vecs[21] = '{1, 0, 0, 1, 1, 0, 1};
    vecs[22] = '{1, 0, 0, 0, 1, 0, 1};
    vecs[23] = '{1, 0, 9, 1, 1, 9, 1};
    @(negedge clk);
    for (int i = 0; i < 24; i++) begin
      drive1(vecs[i].en, vecs[i].hd, int'(vecs[i].lv));
      @(negedge clk);
      check1($sformatf("vec%0d", i), vecs[i].led, vecs[i].exp, int'(vecs[i].cnt), vecs[i].busy);
    end

    // Load-value shrink while counting down from 15
    drive1(0, 0, 15); @(negedge clk);
    drive1(1, 0, 15); @(negedge clk);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (if1.count == 8'd10) found = 1'b1; else @(negedge clk);
    end
    check("shrink.reach10", 32'(found), 1);
    led_save = if1.led;
    drive1(1, 0, 1); @(negedge clk);
    check1("shrink.clamp", led_save, 0, 1, 1);
    @(negedge clk);
    check1("shrink.dec", led_save, 0, 0, 1);
    @(negedge clk);
    check1("shrink.toggle", !led_save, 1, 1, 1);

    // Hold freezes count and led
    drive1(0, 0, 5); @(negedge clk);
    drive1(1, 0, 5); @(negedge clk);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (if1.count == 8'd2) found = 1'b1; else @(negedge clk);
    end
    check("hold.reach2", 32'(found), 1);
    led_save = if1.led;
    drive1(1, 1, 5);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check1($sformatf("hold.c%0d", k), led_save, 0, 2, 1);
    end
    drive1(1, 0, 5);
    @(negedge clk); check1("hold.resume", led_save, 0, 2, 1);
    @(negedge clk); check1("hold.r1", led_save, 0, 1, 1);
    @(negedge clk); check1("hold.r0", led_save, 0, 0, 1);
    @(negedge clk); check1("hold.toggle", !led_save, 1, 5, 1);

    // Disable while led is on, then re-enable
    drive1(0, 0, 2); @(negedge clk);
    drive1(1, 0, 2);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (if1.led) found = 1'b1;
    end
    check("dis.led_on", 32'(found), 1);
    drive1(0, 0, 2); @(negedge clk);
    check1("dis.idle", 0, 0, 0, 0);
    drive1(1, 0, 6); @(negedge clk);
    check1("dis.reenable", 0, 0, 6, 1);
    drive1(0, 0, 0);

    // PRESCALE=4 with load_val=0: one toggle and one expire every 4 cycles
    if4.enable = 1'b1; if4.load_val = 8'd0;
    repeat (3) @(negedge clk);
    led_prev = if4.led; exp_cnt = 0; led_chg = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (if4.expire) begin exp_cnt++; exp_at.push_back(k); end
      if (if4.led != led_prev) led_chg++;
      led_prev = if4.led;
    end
    check("ps4.expires", 32'(exp_cnt), 4);
    check("ps4.toggles", 32'(led_chg), 4);
    for (int k = 1; k < exp_at.size(); k++)
      check($sformatf("ps4.gap%0d", k), 32'(exp_at[k] - exp_at[k-1]), 4);
    if4.enable = 1'b0;
    @(negedge clk);

    // Asynchronous reset mid-run with count=5, led=1
    drive1(1, 0, 5);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (if1.led && if1.count == 8'd5) found = 1'b1;
    end
    check("areset.setup", 32'(found), 1);
    #2 rst_n = 1'b0;
    #1 check1("areset", 0, 0, 0, 0);
    drive1(0, 0, 0);
    @(negedge clk);
    check1("areset.held", 0, 0, 0, 0);
    rst_n = 1'b1;

    // Random run of both instances against the reference model
    m1 = model_reset(1);
    m4 = model_reset(4);
    lv1 = 3; lv4 = 2;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 4) == 0) lv1 = $urandom_range(0, 12);
      if ($urandom_range(0, 4) == 0) lv4 = $urandom_range(0, 6);
      drive1(($urandom_range(0, 15) != 0), ($urandom_range(0, 9) == 0), lv1);
      if4.enable = ($urandom_range(0, 15) != 0);
      if4.hold = ($urandom_range(0, 9) == 0);
      if4.load_val = 8'(lv4);
      @(posedge clk);
      m1 = model_next(m1, if1.enable, if1.hold, int'(if1.load_val));
      m4 = model_next(m4, if4.enable, if4.hold, int'(if4.load_val));
      @(negedge clk);
      check1($sformatf("rnd1[%0d]", i), m1.led, m1.exp, m1.cnt, (m1.mode != 0));
      check($sformatf("rnd4[%0d].led", i), 32'(if4.led), 32'(m4.led));
      check($sformatf("rnd4[%0d].expire", i), 32'(if4.expire), 32'(m4.exp));
      check($sformatf("rnd4[%0d].count", i), 32'(if4.count), m4.cnt);
      check($sformatf("rnd4[%0d].busy", i), 32'(if4.busy), 32'(m4.mode != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
